// File: rtl/alu_cmd_issuer.sv
// Command-side driver for an external combinational ALU: registers one command onto the
// ALU input bus, captures the result a cycle later and returns it over a valid/ready port.
module alu_cmd_issuer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] OP_LAST_VALID = 4'b0110;

    state_t state;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic op_invalid(input logic [3:0] op);
        return op > OP_LAST_VALID;
    endfunction

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            issued_cnt <= '0;
            err_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a      <= cmd_a;
                        alu_b      <= cmd_b;
                        alu_op     <= cmd_op;
                        issued_cnt <= sat_inc(issued_cnt);
                        if (op_invalid(cmd_op)) begin
                            err_cnt <= sat_inc(err_cnt);
                        end
                        state <= EXEC;
                    end
                end
                // ALU output has settled during EXEC; capture it unmodified.
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_err    <= op_invalid(alu_op);
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized self-checking bench for alu_cmd_issuer with a behavioural ALU attached.
module tb_alu_cmd_issuer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_issued = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .issued_cnt(issued_cnt), .err_cnt(err_cnt)
    );

    // Behavioural ALU: ADD SUB AND OR XOR SHL SHR, anything else yields 0.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_result == '0);

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a falling edge with the DUT idle. With stall>0 the consumer holds off
    // for that many cycles while the next command sits on the command port.
    task automatic do_cmd(input logic [3:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int stall,
                          input logic [3:0] nop, input logic [WIDTH-1:0] na,
                          input logic [WIDTH-1:0] nb);
        logic [WIDTH-1:0] er;
        logic             ez;
        logic             ee;
        er = alu_fn(op, a, b);
        ez = (er == '0);
        ee = (op > 4'd6);
        check("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; rsp_ready = 1'b0;
        @(negedge clk);
        exp_issued = sat(exp_issued);
        if (ee) exp_err = sat(exp_err);
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("alu_op", alu_op, op);
        check("issued_cnt", issued_cnt, exp_issued);
        check("err_cnt", err_cnt, exp_err);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_ready", cmd_ready, 0);
        if (stall > 0) begin
            cmd_op = nop; cmd_a = na; cmd_b = nb;
        end else begin
            cmd_valid = 1'b0;
        end
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_result", rsp_result, er);
        check("rsp_zero", rsp_zero, ez);
        check("rsp_err", rsp_err, ee);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_result", rsp_result, er);
            check("stall_err", rsp_err, ee);
            check("stall_ready", cmd_ready, 0);
            check("stall_alu_a", alu_a, a);
            check("stall_issued", issued_cnt, exp_issued);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hs_valid", rsp_valid, 0);
        check("hs_ready", cmd_ready, 1);
        check("hs_result_hold", rsp_result, er);
        check("hs_issued", issued_cnt, exp_issued);
    endtask

    initial begin
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu", {alu_a, alu_b, alu_op} == '0, 1);
        check("rst_rsp", {rsp_result, rsp_zero, rsp_err} == '0, 1);
        check("rst_cnt", {issued_cnt, err_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);

        do_cmd(4'd0, 32'h5, 32'h3, 0, 4'd0, '0, '0);
        do_cmd(4'd1, 32'h1234_5678, 32'h1234_5678, 0, 4'd0, '0, '0);
        do_cmd(4'd5, 32'h1, 32'h24, 0, 4'd0, '0, '0);
        do_cmd(4'b1010, 32'hFFFF_FFFF, 32'h0, 0, 4'd0, '0, '0);
        do_cmd(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5, 4'd6, 32'h8000_0000, 32'h1F);
        do_cmd(4'd6, 32'h8000_0000, 32'h1F, 0, 4'd0, '0, '0);

        // Reset while EXEC: pending command dropped, counters cleared.
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 32'h7; cmd_b = 32'h9;
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b0;
        #1;
        exp_issued = 0; exp_err = 0;
        check("midrst_valid", rsp_valid, 0);
        check("midrst_cnt", {issued_cnt, err_cnt}, 0);
        check("midrst_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", rsp_valid, 0);
        do_cmd(4'd3, 32'hA5A5_0000, 32'h0000_5A5A, 0, 4'd0, '0, '0);

        for (int n = 0; n < 20; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            do_cmd(op, a, b, $urandom_range(0, 3), 4'($urandom_range(0, 15)), $urandom, $urandom);
        end
        check("issued_sat", issued_cnt, CNT_MAX);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
